hdmi_tx_cfg_seq: RTL and testbench

HDMI_TX_CFG_SEQ -- requirements
Module: hdmi_tx_cfg_seq

---
 rtl/hdmi_cfg_pkg.sv | 45 ++++
 rtl/hdmi_tx_cfg_seq.sv | 177 +++++++++++++++++
 tb/tb_hdmi_tx_cfg_seq.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hdmi_cfg_pkg
//  Description : Shared configuration table, FSM state encoding and table
//                lookup helper for the HDMI transmitter configuration sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package hdmi_cfg_pkg;

    // Number of {reg, data} entries written after power-up.
    localparam int CFG_LEN = 4;

    // Entry i lives at CFG_TABLE[i]; upper byte = register, lower byte = value.
    // Index 0 is the rightmost element of the concatenation.
    localparam logic [CFG_LEN-1:0][15:0] CFG_TABLE = {
        16'hAF_16,   // 3: HDMI mode, HDCP off
        16'h9A_E0,   // 2: fixed register required by the transmitter
        16'h98_03,   // 1: fixed register required by the transmitter
        16'h41_10    // 0: main power-up
    };

    // Sequencer states, explicit 3-bit encoding.
    typedef enum logic [2:0] {
        ST_WAIT_PWR = 3'd0,
        ST_LOAD     = 3'd1,
        ST_REQ      = 3'd2,
        ST_GAP      = 3'd3,
        ST_DONE     = 3'd4,
        ST_FAIL     = 3'd5
    } cfg_state_e;

    // Table lookup by index; out-of-range indices return zero.
    function automatic logic [15:0] cfg_entry(input logic [7:0] idx);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < CFG_LEN; i++) begin
            if (idx == 8'(i)) begin
                v = CFG_TABLE[i];
            end
        end
        return v;
    endfunction

endpackage : hdmi_cfg_pkg
`default_nettype wire

// File: rtl/hdmi_tx_cfg_seq.sv
`default_nettype none
// ============================================================================
//  Module      : hdmi_tx_cfg_seq
//  Description : Walks the HDMI transmitter configuration table after a
//                power-up delay, issuing one I2C write per entry with bounded
//                retries; restarts on a start pulse or an hpd rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module hdmi_tx_cfg_seq
    import hdmi_cfg_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR  = 7'h39,
    parameter int         PWR_WAIT  = 10_000_000,
    parameter int         MAX_RETRY = 3
) (
    input  logic       clk50,
    input  logic       rst,
    input  logic       start,
    input  logic       hpd,
    output logic       wr_req,
    output logic [6:0] wr_dev,
    output logic [7:0] wr_reg,
    output logic [7:0] wr_data,
    input  logic       wr_ack,
    input  logic       wr_err,
    output logic       busy,
    output logic       done,
    output logic       error
);

    // Counter widths; at least one bit so degenerate parameters still elaborate.
    localparam int c_idx_w = (CFG_LEN   > 0) ? $clog2(CFG_LEN + 1)   : 1;
    localparam int c_pwr_w = (PWR_WAIT  > 0) ? $clog2(PWR_WAIT + 1)  : 1;
    localparam int c_rty_w = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [c_idx_w-1:0] c_last_idx  = c_idx_w'(CFG_LEN - 1);
    localparam logic [c_pwr_w-1:0] c_pwr_wait  = c_pwr_w'(PWR_WAIT);
    localparam logic [c_rty_w-1:0] c_max_retry = c_rty_w'(MAX_RETRY);

    cfg_state_e          r_state,   w_state_nxt;
    logic [c_idx_w-1:0]  r_idx,     w_idx_nxt;
    logic [c_rty_w-1:0]  r_retry,   w_retry_nxt;
    logic [c_pwr_w-1:0]  r_pwr_cnt, w_pwr_cnt_nxt;
    logic                r_rst_pend, w_rst_pend_nxt;
    logic                r_last_ok, w_last_ok_nxt;
    logic [7:0]          r_wr_reg,  w_wr_reg_nxt;
    logic [7:0]          r_wr_data, w_wr_data_nxt;
    logic                r_hpd_s1, r_hpd_s2, r_hpd_prev;
    logic                w_restart;
    logic [15:0]         w_entry;

    // Two-flop synchroniser for hpd plus one flop for rising-edge detection.
    always_ff @(posedge clk50) begin
        if (rst) begin
            r_hpd_s1   <= 1'b0;
            r_hpd_s2   <= 1'b0;
            r_hpd_prev <= 1'b0;
        end else begin
            r_hpd_s1   <= hpd;
            r_hpd_s2   <= r_hpd_s1;
            r_hpd_prev <= r_hpd_s2;
        end
    end

    assign w_restart = start | (r_hpd_s2 & ~r_hpd_prev);
    assign w_entry   = cfg_entry(8'(r_idx));

    // State and datapath registers.
    always_ff @(posedge clk50) begin
        if (rst) begin
            r_state    <= ST_WAIT_PWR;
            r_idx      <= '0;
            r_retry    <= '0;
            r_pwr_cnt  <= '0;
            r_rst_pend <= 1'b0;
            r_last_ok  <= 1'b0;
            r_wr_reg   <= '0;
            r_wr_data  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_retry    <= w_retry_nxt;
            r_pwr_cnt  <= w_pwr_cnt_nxt;
            r_rst_pend <= w_rst_pend_nxt;
            r_last_ok  <= w_last_ok_nxt;
            r_wr_reg   <= w_wr_reg_nxt;
            r_wr_data  <= w_wr_data_nxt;
        end
    end

    // Next-state logic: the handshake outcome is captured in REQ and acted on
    // in GAP, so GAP is the single place where restart/advance/retry/fail is
    // decided. A restart seen during REQ is held until the handshake ends.
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_retry_nxt    = r_retry;
        w_pwr_cnt_nxt  = r_pwr_cnt;
        w_rst_pend_nxt = r_rst_pend;
        w_last_ok_nxt  = r_last_ok;
        w_wr_reg_nxt   = r_wr_reg;
        w_wr_data_nxt  = r_wr_data;
        case (r_state)
            ST_WAIT_PWR: begin
                if (r_pwr_cnt == c_pwr_wait) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_pwr_cnt_nxt = r_pwr_cnt + c_pwr_w'(1);
                end
            end
            ST_LOAD: begin
                if (w_restart) begin
                    w_idx_nxt   = '0;
                    w_retry_nxt = '0;
                end else begin
                    w_wr_reg_nxt  = w_entry[15:8];
                    w_wr_data_nxt = w_entry[7:0];
                    w_state_nxt   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (w_restart) begin
                    w_rst_pend_nxt = 1'b1;
                end
                // An error wins over a simultaneous ack.
                if (wr_err) begin
                    w_last_ok_nxt = 1'b0;
                    w_state_nxt   = ST_GAP;
                end else if (wr_ack) begin
                    w_last_ok_nxt = 1'b1;
                    w_state_nxt   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_restart || r_rst_pend) begin
                    w_idx_nxt      = '0;
                    w_retry_nxt    = '0;
                    w_rst_pend_nxt = 1'b0;
                    w_state_nxt    = ST_LOAD;
                end else if (r_last_ok) begin
                    w_retry_nxt = '0;
                    if (r_idx == c_last_idx) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_idx_nxt   = r_idx + c_idx_w'(1);
                        w_state_nxt = ST_LOAD;
                    end
                end else if (r_retry < c_max_retry) begin
                    w_retry_nxt = r_retry + c_rty_w'(1);
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_FAIL;
                end
            end
            ST_DONE, ST_FAIL: begin
                if (w_restart) begin
                    w_idx_nxt   = '0;
                    w_retry_nxt = '0;
                    w_state_nxt = ST_LOAD;
                end
            end
            default: begin
                w_state_nxt = ST_WAIT_PWR;
            end
        endcase
    end

    assign wr_req  = (r_state == ST_REQ);
    assign wr_dev  = DEV_ADDR;
    assign wr_reg  = r_wr_reg;
    assign wr_data = r_wr_data;
    assign done    = (r_state == ST_DONE);
    assign error   = (r_state == ST_FAIL);
    assign busy    = ~(done | error);

endmodule : hdmi_tx_cfg_seq
`default_nettype wire

// File: tb/tb_hdmi_tx_cfg_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hdmi_tx_cfg_seq
//  Description : Directed self-checking bench for hdmi_tx_cfg_seq with a
//                behavioural write engine that answers 3 cycles after wr_req.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hdmi_tx_cfg_seq;

    logic       clk50 = 1'b0;
    logic       rst, start, hpd, wr_ack, wr_err;
    logic       wr_req, busy, done, error;
    logic [6:0] wr_dev;
    logic [7:0] wr_reg, wr_data;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected table contents, written out by hand.
    logic [7:0] e_reg [4] = '{8'h41, 8'h98, 8'h9A, 8'hAF};
    logic [7:0] e_dat [4] = '{8'h10, 8'h03, 8'hE0, 8'h16};

    // Write-engine model state.
    logic [15:0] log_q [$];
    logic [15:0] cur;
    logic [7:0]  fail_reg = 8'h00;
    int          fail_n = 0, fail_hits = 0, stab_bad = 0, late_bad = 0, n_resp = 0;
    bit          both_mode = 0, in_req = 0, do_err = 0, pulsed = 0;

    always #5 clk50 = ~clk50;

    hdmi_tx_cfg_seq #(
        .DEV_ADDR (7'h39),
        .PWR_WAIT (16),
        .MAX_RETRY(3)
    ) dut (
        .clk50  (clk50),
        .rst    (rst),
        .start  (start),
        .hpd    (hpd),
        .wr_req (wr_req),
        .wr_dev (wr_dev),
        .wr_reg (wr_reg),
        .wr_data(wr_data),
        .wr_ack (wr_ack),
        .wr_err (wr_err),
        .busy   (busy),
        .done   (done),
        .error  (error)
    );

    // Write engine: logs each new request, answers on the 3rd cycle of wr_req,
    // errors on the first fail_n requests that target fail_reg.
    initial begin
        wr_ack = 1'b0;
        wr_err = 1'b0;
        forever begin
            @(negedge clk50);
            if (pulsed && wr_req) late_bad++;
            pulsed = 0;
            wr_ack = 1'b0;
            wr_err = 1'b0;
            if (wr_req) begin
                if (!in_req) begin
                    in_req = 1;
                    n_resp = 0;
                    cur    = {wr_reg, wr_data};
                    log_q.push_back(cur);
                    if (wr_reg == fail_reg) begin
                        fail_hits++;
                        do_err = (fail_hits <= fail_n);
                    end else begin
                        do_err = 0;
                    end
                end else if ({wr_reg, wr_data} !== cur) begin
                    stab_bad++;
                end
                n_resp++;
                if (n_resp == 3) begin
                    if (do_err) begin
                        wr_err = 1'b1;
                        wr_ack = both_mode;
                    end else begin
                        wr_ack = 1'b1;
                    end
                    pulsed = 1;
                    in_req = 0;
                end
            end else begin
                in_req = 0;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk50);
        start = 1'b1;
        @(negedge clk50);
        start = 1'b0;
    endtask

    task automatic set_policy(input logic [7:0] reg_a, input int n, input bit both);
        fail_reg  = reg_a;
        fail_n    = n;
        both_mode = both;
        fail_hits = 0;
        log_q.delete();
    endtask

    task automatic wait_end(output bit ok);
        ok = 0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk50);
            if (done || error) ok = 1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; hpd = 1'b0;
        repeat (3) @(negedge clk50);
        n_cmp++; if (wr_req !== 1'b0)   begin n_bad++; $display("FAIL reset_wr_req got %b want 0", wr_req); end
        n_cmp++; if (busy !== 1'b1)     begin n_bad++; $display("FAIL reset_busy got %b want 1", busy); end
        n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (error !== 1'b0)    begin n_bad++; $display("FAIL reset_error got %b want 0", error); end
        n_cmp++; if ({wr_reg, wr_data} !== 16'h0000) begin n_bad++; $display("FAIL reset_reg_data got %h want 0000", {wr_reg, wr_data}); end
        n_cmp++; if (wr_dev !== 7'h39)  begin n_bad++; $display("FAIL reset_wr_dev got %h want 39", wr_dev); end
    endtask

    task automatic test_power_up();
        int cyc;
        bit ok;
        rst = 1'b0;
        cyc = 0;
        while (!wr_req && cyc < 100) begin
            @(negedge clk50);
            cyc++;
        end
        n_cmp++; if (cyc !== 18) begin n_bad++; $display("FAIL pwr_first_req_cycle got %0d want 18", cyc); end
        wait_end(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL pwr_timeout got no done want done"); end
        n_cmp++; if (log_q.size() !== 4) begin n_bad++; $display("FAIL pwr_write_count got %0d want 4", log_q.size()); end
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            n_cmp++;
            if (log_q[i] !== {e_reg[i], e_dat[i]}) begin
                n_bad++; $display("FAIL pwr_entry%0d got %h want %h", i, log_q[i], {e_reg[i], e_dat[i]});
            end
        end
        n_cmp++; if ({done, busy, error} !== 3'b100) begin n_bad++; $display("FAIL pwr_status got done/busy/err=%b want 100", {done, busy, error}); end
    endtask

    task automatic test_retry();
        int exp_idx [6] = '{0, 1, 1, 1, 2, 3};
        bit ok;
        set_policy(8'h98, 2, 0);
        pulse_start();
        wait_end(ok);
        n_cmp++; if (!ok || done !== 1'b1) begin n_bad++; $display("FAIL retry_done got %b want 1", done); end
        n_cmp++; if (log_q.size() !== 6) begin n_bad++; $display("FAIL retry_write_count got %0d want 6", log_q.size()); end
        for (int i = 0; i < 6 && i < log_q.size(); i++) begin
            n_cmp++;
            if (log_q[i] !== {e_reg[exp_idx[i]], e_dat[exp_idx[i]]}) begin
                n_bad++; $display("FAIL retry_write%0d got %h want %h", i, log_q[i], {e_reg[exp_idx[i]], e_dat[exp_idx[i]]});
            end
        end
    endtask

    task automatic test_fail();
        int exp_idx [6] = '{0, 1, 2, 2, 2, 2};
        bit ok;
        set_policy(8'h9A, 1000, 0);
        pulse_start();
        wait_end(ok);
        repeat (20) @(negedge clk50);
        n_cmp++; if ({error, busy, done, wr_req} !== 4'b1000) begin n_bad++; $display("FAIL fail_status got err/busy/done/req=%b want 1000", {error, busy, done, wr_req}); end
        n_cmp++; if (log_q.size() !== 6) begin n_bad++; $display("FAIL fail_write_count got %0d want 6", log_q.size()); end
        for (int i = 0; i < 6 && i < log_q.size(); i++) begin
            n_cmp++;
            if (log_q[i] !== {e_reg[exp_idx[i]], e_dat[exp_idx[i]]}) begin
                n_bad++; $display("FAIL fail_write%0d got %h want %h", i, log_q[i], {e_reg[exp_idx[i]], e_dat[exp_idx[i]]});
            end
        end
    endtask

    task automatic test_simultaneous();
        int exp_idx [5] = '{0, 0, 1, 2, 3};
        bit ok;
        set_policy(8'h41, 1, 1);
        pulse_start();
        n_cmp++; if ({error, busy} !== 2'b01) begin n_bad++; $display("FAIL sim_restart_status got err/busy=%b want 01", {error, busy}); end
        wait_end(ok);
        n_cmp++; if (!ok || done !== 1'b1) begin n_bad++; $display("FAIL sim_done got %b want 1", done); end
        n_cmp++; if (log_q.size() !== 5) begin n_bad++; $display("FAIL sim_write_count got %0d want 5", log_q.size()); end
        for (int i = 0; i < 5 && i < log_q.size(); i++) begin
            n_cmp++;
            if (log_q[i] !== {e_reg[exp_idx[i]], e_dat[exp_idx[i]]}) begin
                n_bad++; $display("FAIL sim_write%0d got %h want %h", i, log_q[i], {e_reg[exp_idx[i]], e_dat[exp_idx[i]]});
            end
        end
    endtask

    task automatic test_hotplug();
        int exp_idx [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        bit ok, seen;
        set_policy(8'h00, 0, 0);
        pulse_start();
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk50);
            if (wr_req && wr_reg == 8'hAF) seen = 1;
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL hpd_entry3_timeout got none want entry3 request"); end
        hpd = 1'b1;
        wait_end(ok);
        hpd = 1'b0;
        n_cmp++; if (!ok || done !== 1'b1) begin n_bad++; $display("FAIL hpd_done got %b want 1", done); end
        n_cmp++; if (log_q.size() !== 8) begin n_bad++; $display("FAIL hpd_write_count got %0d want 8", log_q.size()); end
        for (int i = 0; i < 8 && i < log_q.size(); i++) begin
            n_cmp++;
            if (log_q[i] !== {e_reg[exp_idx[i]], e_dat[exp_idx[i]]}) begin
                n_bad++; $display("FAIL hpd_write%0d got %h want %h", i, log_q[i], {e_reg[exp_idx[i]], e_dat[exp_idx[i]]});
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok, seen;
        int cyc;
        set_policy(8'h00, 0, 0);
        pulse_start();
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk50);
            if (wr_req && wr_reg == 8'h98) seen = 1;
        end
        rst = 1'b1;
        @(negedge clk50);
        n_cmp++; if ({wr_req, busy} !== 2'b01) begin n_bad++; $display("FAIL rstmid_drop got req/busy=%b want 01", {wr_req, busy}); end
        @(negedge clk50);
        rst = 1'b0;
        log_q.delete();
        cyc = 0;
        while (!wr_req && cyc < 100) begin
            @(negedge clk50);
            cyc++;
        end
        n_cmp++; if (cyc !== 18) begin n_bad++; $display("FAIL rstmid_pwr_delay got %0d want 18", cyc); end
        n_cmp++; if (wr_reg !== 8'h41) begin n_bad++; $display("FAIL rstmid_first_reg got %h want 41", wr_reg); end
        wait_end(ok);
        n_cmp++; if (!ok || log_q.size() !== 4) begin n_bad++; $display("FAIL rstmid_rewrite got %0d writes want 4", log_q.size()); end
    endtask

    task automatic test_protocol();
        n_cmp++; if (stab_bad !== 0) begin n_bad++; $display("FAIL req_stability got %0d changes want 0", stab_bad); end
        n_cmp++; if (late_bad !== 0) begin n_bad++; $display("FAIL req_drop_after_resp got %0d late want 0", late_bad); end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_retry();
        test_fail();
        test_simultaneous();
        test_hotplug();
        test_reset_mid();
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_hdmi_tx_cfg_seq
`default_nettype wire
